xdisp_mux: RTL and testbench
============================

Name: xdisp_mux

Overview:
- Memory-mapped, multiplexed seven-segment display controller for N digits. Sits on the data bus beside xleds and xregf.
- The address decoder drives its select line. Software writes digit values and control masks; the block scans the digits autonomously.
- Supersedes the fixed 4-digit, switch-driven display test with these additions:
  - parametrised digit count and scan rate;
  - per-digit decimal point and blanking;
  - bus read-back.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8; N_DIGITS*4 <= DATA_W)
DIV_W, 16, refresh prescaler width; each digit is shown for 2^DIV_W clk cycles
DATA_W, 32, bus data width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
sel  input  1  register access select from address decoder
we  input  1  write enable (valid with sel)
addr  input  2  register index
data_in  input  DATA_W  write data
data_out  output  DATA_W  read data
disp  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
disp_sel  output  N_DIGITS  digit anodes, active-low, one-hot-low when lit

Behaviour:
- Reset is asynchronous and active-low, with one clock.
- Reset values: all value/dp/blank registers 0; prescaler 0; scan index 0; disp = 8'hFF; disp_sel = all ones; data_out = 0.
- Register map (write when sel & we at a rising clk edge):
  - addr 0 VALUE: nibble i = hex value of digit i; bits above N_DIGITS*4 ignored, read as 0.
  - addr 1 DP: bit i lights the decimal point of digit i.
  - addr 2 BLANK: bit i = 1 forces digit i dark (anode held high during its slot).
  - addr 3 BLINK (only with the option, see below); otherwise writes ignored, reads 0.
- Read: data_out is combinational, equal to the addressed register when sel & ~we, else 0.
- Prescaler: free-running DIV_W-bit counter.
  - When it equals all-ones, the scan index advances on the next edge.
  - The index wraps from N_DIGITS-1 to 0.
  - With N_DIGITS=1, the index stays 0.
- Scan state machine: two states, BLANK_GAP and DRIVE.
  - On each index advance, enter BLANK_GAP for exactly 1 cycle: disp_sel all ones, disp = 8'hFF (anti-ghosting).
  - Then DRIVE for the remainder of the slot.
- DRIVE outputs (registered, computed from current registers and index):
  - disp_sel bit[index] = 0, other bits 1.
  - disp[6:0] = active-low hex decode of nibble[index] (0-F, full set: A,b,C,d,E,F).
  - disp[7] = ~DP[index].
- Blanked digit: disp_sel all ones and disp = 8'hFF for its entire slot. The scan timing is unchanged.
- Write latency: a write at edge t is visible on disp at edge t+1 if that digit is in DRIVE; otherwise at its next slot.
- Simultaneous write and index advance: the new value is used from the following DRIVE cycle.
- Reset mid-scan: outputs immediately go to reset values (asynchronous); scanning restarts at digit 0 after release.

Optional Feature:
- Macro: XDISP_BLINK_EN.
- Defined:
  - Adds register addr 3 BLINK (bit i per digit) and an 8-bit slot-wrap counter, which increments each time the index wraps N_DIGITS-1 -> 0.
  - While counter bit 7 = 1, digits with BLINK bit set are treated as blanked.
  - BLINK and the counter reset to 0.
- Undefined: no BLINK register or counter; addr 3 reads 0 and writes have no effect.

Test Plan:
- Reset and scan: DIV_W=2, N_DIGITS=4, assert rst=0 then release.
  - During reset: disp=FF, disp_sel=F.
  - After release: disp_sel sequence E,D,B,7 repeating, each slot 4 cycles including 1 gap cycle (disp_sel=F).
- Hex decode: write VALUE=32'h0000_8A1F.
  - disp[6:0] per slot = 0E (F), 79 (1), 08 (A), 00 (8).
  - disp[7]=1 throughout.
- DP, blank and read-back:
  - Write DP=4'b0101, BLANK=4'b0010.
  - Digits 0 and 2 show disp[7]=0.
  - Digit 1 slot shows disp_sel=F, disp=FF for all 4 cycles.
  - Reading addr 1 returns 5; addr 2 returns 2; addr 3 returns 0 (option off).
- Mid-slot write: write VALUE nibble 0 from 0 to 5 while digit 0 is in DRIVE.
  - Next cycle disp[6:0] = 12.
  - The slot does not lengthen.
- Async reset mid-operation: drop rst between clk edges during a DRIVE cycle.
  - Outputs go to FF/F before the next edge.
  - All registers read 0 after release.
- XDISP_BLINK_EN: set BLINK=4'b0001.
  - Digit 0 dark for 128 scan wraps, lit for 128, repeating.
  - Other digits are unaffected.

Source files
------------

// File: rtl/xdisp_mux.sv
// xdisp_mux: memory-mapped multiplexed seven-segment controller for N_DIGITS digits.
// Latency: bus writes reach the display on the next edge when the digit is driving; reads are combinational.
// Backpressure: none; the bus is always accepted. Optional build macro XDISP_BLINK_EN adds the BLINK register.
module xdisp_mux #(
    parameter int N_DIGITS = 4,
    parameter int DIV_W    = 16,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic [7:0]          disp,
    output logic [N_DIGITS-1:0] disp_sel
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VAL_W = N_DIGITS * 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    // Scan FSM encoding
    localparam logic [0:0] ST_GAP   = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // Software-visible registers
    logic [VAL_W-1:0]    value_q, value_d;
    logic [N_DIGITS-1:0] dp_q, dp_d;
    logic [N_DIGITS-1:0] blank_q, blank_d;

    // Scan machinery
    logic [DIV_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [0:0]          state_q, state_d;
    logic [7:0]          disp_q, disp_d;
    logic [N_DIGITS-1:0] disp_sel_q, disp_sel_d;

    logic                wr_en;
    logic                rd_en;
    logic                advance;
    logic [N_DIGITS-1:0] dark_mask;
    logic                digit_dark;
    logic [3:0]          nibble;
    logic [N_DIGITS-1:0] anode_drv;

    assign wr_en   = sel & we;
    assign rd_en   = sel & ~we;
    assign advance = (pre_q == {DIV_W{1'b1}});

`ifdef XDISP_BLINK_EN
    logic [N_DIGITS-1:0] blink_q, blink_d;
    logic [7:0]          wrap_q, wrap_d;

    // BLINK register write and full-scan wrap counter that sets the blink period
    always_comb begin
        blink_d = blink_q;
        wrap_d  = wrap_q;
        if (wr_en && addr == 2'd3) begin
            blink_d = data_in[N_DIGITS-1:0];
        end
        if (advance && idx_q == LAST_IDX) begin
            wrap_d = wrap_q + 8'd1;
        end
    end

    // Blink state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_q <= '0;
            wrap_q  <= '0;
        end else begin
            blink_q <= blink_d;
            wrap_q  <= wrap_d;
        end
    end

    // Blinking digits count as blanked during the upper half of the wrap count
    assign dark_mask = blank_q | (blink_q & {N_DIGITS{wrap_q[7]}});
`else
    assign dark_mask = blank_q;
`endif

    // Upper write-data bits have no storage when the digit field is narrower than the bus
    generate
        if (VAL_W < DATA_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^data_in[DATA_W-1:VAL_W];
        end
    endgenerate

    // Register-map writes
    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        if (wr_en) begin
            case (addr)
                2'd0:    value_d = data_in[VAL_W-1:0];
                2'd1:    dp_d    = data_in[N_DIGITS-1:0];
                2'd2:    blank_d = data_in[N_DIGITS-1:0];
                default: ;
            endcase
        end
    end

    // Combinational read-back, zero when not selected for reading
    always_comb begin
        data_out = '0;
        if (rd_en) begin
            case (addr)
                2'd0: data_out = DATA_W'(value_q);
                2'd1: data_out = DATA_W'(dp_q);
                2'd2: data_out = DATA_W'(blank_q);
`ifdef XDISP_BLINK_EN
                2'd3: data_out = DATA_W'(blink_q);
`endif
                default: data_out = '0;
            endcase
        end
    end

    // Prescaler and scan index; index moves on the edge after the prescaler hits all-ones
    always_comb begin
        pre_d = pre_q + DIV_W'(1);
        idx_d = idx_q;
        if (advance) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Scan FSM: one gap cycle after every index advance, then drive for the rest of the slot
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GAP:   state_d = advance ? ST_GAP : ST_DRIVE;
            ST_DRIVE: state_d = advance ? ST_GAP : ST_DRIVE;
            default:  state_d = ST_GAP;
        endcase
    end

    // One-low anode pattern for the current index
    always_comb begin
        anode_drv = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            anode_drv[i] = (idx_q != IDX_W'(i));
        end
    end

    assign nibble     = value_q[{idx_q, 2'b00} +: 4];
    assign digit_dark = dark_mask[idx_q];

    // Next display outputs: dark during the gap or for a blanked digit, else decoded digit
    always_comb begin
        disp_d     = 8'hFF;
        disp_sel_d = '1;
        if (state_d == ST_DRIVE && !digit_dark) begin
            disp_d     = {~dp_q[idx_q], hex7(nibble)};
            disp_sel_d = anode_drv;
        end
    end

    // All state, cleared asynchronously; a reset is treated as digit 0's gap cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q    <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            pre_q      <= '0;
            idx_q      <= '0;
            state_q    <= ST_GAP;
            disp_q     <= 8'hFF;
            disp_sel_q <= '1;
        end else begin
            value_q    <= value_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            disp_q     <= disp_d;
            disp_sel_q <= disp_sel_d;
        end
    end

    assign disp     = disp_q;
    assign disp_sel = disp_sel_q;

    // Active-low {g,f,e,d,c,b,a} hex glyphs
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endmodule

// File: tb/tb_xdisp_mux.sv
// Bench for xdisp_mux with N_DIGITS=4, DIV_W=2 (4-cycle slots), DATA_W=32.
// Outputs sampled 1 time unit after each rising edge and compared to a slot/phase model.
// Build with XDISP_BLINK_EN defined to exercise the blink register.
module tb_xdisp_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  disp;
    logic [3:0]  disp_sel;

    int vectors = 0;
    int miscompares = 0;

    // Model state: registers, edges since reset release, expected outputs
    int         e;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_blank, m_blink;
    logic [7:0]  x_disp;
    logic [3:0]  x_sel;

    xdisp_mux #(.N_DIGITS(4), .DIV_W(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .disp(disp), .disp_sel(disp_sel)
    );

    always #5 clk = ~clk;

    // Active-high gfedcba glyph, inverted for the active-low segments
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] hi;
        case (n)
            4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    // Expected outputs after edge ee: slot = ee/4, first cycle of each slot is the gap
    task automatic predict(input int ee);
        int  idx;
        bit  dark;
        idx  = (ee / 4) % 4;
        dark = m_blank[idx];
`ifdef XDISP_BLINK_EN
        if (ee > 0 && (((ee - 1) / 16) % 256) >= 128 && m_blink[idx]) dark = 1'b1;
`endif
        if ((ee % 4) == 0 || dark) begin
            x_disp = 8'hFF;
            x_sel  = 4'hF;
        end else begin
            x_disp = {~m_dp[idx], seg_of(m_val[idx*4 +: 4])};
            x_sel  = ~(4'b0001 << idx);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return {16'h0, m_val};
            2'd1: return {28'h0, m_dp};
            2'd2: return {28'h0, m_blank};
`ifdef XDISP_BLINK_EN
            default: return {28'h0, m_blink};
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    task automatic model_clear();
        e = 0; m_val = '0; m_dp = '0; m_blank = '0; m_blink = '0;
    endtask

    // One clock edge, optionally carrying a write; leaves time at edge+1
    task automatic tick(input bit w, input logic [1:0] a, input logic [31:0] d);
        sel = w; we = w; addr = a; data_in = d;
        e = e + 1;
        predict(e);
        if (w) begin
            case (a)
                2'd0: m_val   = d[15:0];
                2'd1: m_dp    = d[3:0];
                2'd2: m_blank = d[3:0];
                default: begin
`ifdef XDISP_BLINK_EN
                    m_blink = d[3:0];
`endif
                end
            endcase
        end
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (disp !== 8'hFF || disp_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_out disp=%h sel=%h exp FF/F", disp, disp_sel);
        end
        for (int a = 0; a < 4; a++) begin
            sel = 1'b1; addr = a[1:0]; #1;
            vectors++;
            if (data_out !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d got=%h exp=0", a, data_out);
            end
        end
        sel = 1'b0;
        #1 rst = 1'b1;
        #1;
        predict(0);
        vectors++;
        if (disp !== x_disp || disp_sel !== x_sel) begin
            miscompares++;
            $display("FAIL release_gap disp=%h sel=%h exp=%h/%h", disp, disp_sel, x_disp, x_sel);
        end
    endtask

    task automatic test_scan();
        logic [3:0] lit_tab [4];
        lit_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int k = 0; k < 32; k++) begin
            tick(0, 2'd0, 32'h0);
            vectors++;
            if (disp_sel !== (((e % 4) == 0) ? 4'hF : lit_tab[(e / 4) % 4])) begin
                miscompares++;
                $display("FAIL scan_sel e=%0d got=%h", e, disp_sel);
            end
            vectors++;
            if (disp !== x_disp) begin
                miscompares++;
                $display("FAIL scan_disp e=%0d got=%h exp=%h", e, disp, x_disp);
            end
        end
    endtask

    task automatic test_hex_decode();
        logic [6:0] seg_tab [4];
        seg_tab = '{7'h0E, 7'h79, 7'h08, 7'h00};
        tick(1, 2'd0, 32'h0000_8A1F);
        for (int k = 0; k < 20; k++) tick(0, 2'd0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            tick(0, 2'd0, 32'h0);
            if ((e % 4) != 0) begin
                vectors++;
                if (disp !== {1'b1, seg_tab[(e / 4) % 4]}) begin
                    miscompares++;
                    $display("FAIL hex e=%0d got=%h exp=%h", e, disp, {1'b1, seg_tab[(e / 4) % 4]});
                end
            end
        end
    endtask

    task automatic test_dp_blank_readback();
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0000_8A1F, 32'h5, 32'h2, 32'h0};
        tick(1, 2'd1, 32'h5);
        tick(1, 2'd2, 32'h2);
        for (int k = 0; k < 32; k++) begin
            tick(0, 2'd0, 32'h0);
            vectors++;
            if (disp !== x_disp || disp_sel !== x_sel) begin
                miscompares++;
                $display("FAIL dp_blank e=%0d got=%h/%h exp=%h/%h", e, disp, disp_sel, x_disp, x_sel);
            end
            if ((e / 4) % 4 == 1) begin
                vectors++;
                if (disp !== 8'hFF || disp_sel !== 4'hF) begin
                    miscompares++;
                    $display("FAIL blanked_digit e=%0d got=%h/%h exp=FF/F", e, disp, disp_sel);
                end
            end
        end
        for (int a = 0; a < 4; a++) begin
            sel = 1'b1; addr = a[1:0]; #1;
            vectors++;
            if (data_out !== exp_rd[a]) begin
                miscompares++;
                $display("FAIL readback addr=%0d got=%h exp=%h", a, data_out, exp_rd[a]);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] ra;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) tick(1, 2'($urandom_range(3)), $urandom);
            else                        tick(0, 2'd0, 32'h0);
            vectors++;
            if (disp !== x_disp || disp_sel !== x_sel) begin
                miscompares++;
                $display("FAIL random e=%0d got=%h/%h exp=%h/%h", e, disp, disp_sel, x_disp, x_sel);
            end
            ra = 2'($urandom_range(3));
            sel = 1'b1; addr = ra; #1;
            vectors++;
            if (data_out !== model_read(ra)) begin
                miscompares++;
                $display("FAIL random_read addr=%0d got=%h exp=%h", ra, data_out, model_read(ra));
            end
            sel = 1'b0;
        end
    endtask

    task automatic test_midslot_write();
        tick(1, 2'd2, 32'h0);
        tick(1, 2'd0, 32'h0);
        while ((e % 16) != 1) tick(0, 2'd0, 32'h0);
        tick(1, 2'd0, 32'h5);
        vectors++;
        if (disp[6:0] !== 7'h40) begin
            miscompares++;
            $display("FAIL mid_old got=%h exp=40", disp[6:0]);
        end
        tick(0, 2'd0, 32'h0);
        vectors++;
        if (disp[6:0] !== 7'h12 || disp_sel !== 4'hE) begin
            miscompares++;
            $display("FAIL mid_new got=%h/%h exp=12/E", disp[6:0], disp_sel);
        end
        tick(0, 2'd0, 32'h0);
        vectors++;
        if (disp_sel !== 4'hF || disp !== 8'hFF) begin
            miscompares++;
            $display("FAIL mid_gap got=%h/%h exp=FF/F", disp, disp_sel);
        end
        tick(0, 2'd0, 32'h0);
        vectors++;
        if (disp_sel !== 4'hD || disp !== x_disp) begin
            miscompares++;
            $display("FAIL mid_next got=%h/%h exp=%h/D", disp, disp_sel, x_disp);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 48; k++) begin
            tick(1, 2'($urandom_range(2)), $urandom);
            vectors++;
            if (disp !== x_disp || disp_sel !== x_sel) begin
                miscompares++;
                $display("FAIL b2b e=%0d got=%h/%h exp=%h/%h", e, disp, disp_sel, x_disp, x_sel);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1, 2'd0, 32'h1234);
        tick(1, 2'd1, 32'hF);
        while ((e % 4) != 2 || m_blank[(e / 4) % 4]) tick(0, 2'd0, 32'h0);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (disp !== 8'hFF || disp_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL async_out disp=%h sel=%h exp FF/F", disp, disp_sel);
        end
        #1 rst = 1'b1;
        model_clear();
        for (int a = 0; a < 4; a++) begin
            sel = 1'b1; addr = a[1:0]; #1;
            vectors++;
            if (data_out !== 32'h0) begin
                miscompares++;
                $display("FAIL async_read addr=%0d got=%h exp=0", a, data_out);
            end
        end
        sel = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(0, 2'd0, 32'h0);
            vectors++;
            if (disp !== x_disp || disp_sel !== x_sel) begin
                miscompares++;
                $display("FAIL restart e=%0d got=%h/%h exp=%h/%h", e, disp, disp_sel, x_disp, x_sel);
            end
        end
    endtask

`ifdef XDISP_BLINK_EN
    task automatic test_blink();
        tick(1, 2'd0, 32'h0000_4321);
        tick(1, 2'd3, 32'h1);
        while (e < 16 * 260) begin
            tick(0, 2'd0, 32'h0);
            vectors++;
            if (disp !== x_disp || disp_sel !== x_sel) begin
                miscompares++;
                $display("FAIL blink e=%0d got=%h/%h exp=%h/%h", e, disp, disp_sel, x_disp, x_sel);
            end
        end
    endtask
`else
    task automatic test_addr3();
        tick(1, 2'd3, 32'hFFFF_FFFF);
        sel = 1'b1; addr = 2'd3; #1;
        vectors++;
        if (data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL addr3_read got=%h exp=0", data_out);
        end
        sel = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick(0, 2'd0, 32'h0);
            vectors++;
            if (disp !== x_disp || disp_sel !== x_sel) begin
                miscompares++;
                $display("FAIL addr3_scan e=%0d got=%h/%h exp=%h/%h", e, disp, disp_sel, x_disp, x_sel);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_hex_decode();
        test_dp_blank_readback();
        test_random();
        test_midslot_write();
        test_back_to_back();
        test_async_reset();
`ifdef XDISP_BLINK_EN
        test_blink();
`else
        test_addr3();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
